mult_shift_add_ctrl: RTL and testbench

//   Control FSM for the shift-add multiplier datapath (B/C/A/Q registers, adder, P down-counter).

---
 rtl/mult_shift_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_mult_shift_add_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_shift_add_ctrl.sv
// Sequencer for the shift-add multiplier datapath: accepts an operand pair,
// walks Load/Check/Add/Shift per bit, then holds the product until consumed.
module mult_shift_add_ctrl #(
  parameter int BITS       = 8,
  parameter bit CHECK_ZERO = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_valid,
  output logic                start_ready,
  input  logic [BITS-1:0]     op_b,
  input  logic [BITS-1:0]     op_q,
  input  logic                Q0,
  input  logic                Zero,
  input  logic [2*BITS:0]     Producto,
  output logic                Load_Regs,
  output logic                Add_Regs,
  output logic                Shift_Regs,
  output logic                Decr_P,
  output logic [BITS-1:0]     DP_B,
  output logic [BITS-1:0]     DP_Q,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [2*BITS-1:0]   res_product,
  output logic                busy,
  output logic                err
);

  localparam int CW = $clog2(BITS + 1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ADD, SHIFT, DONE} state_t;

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [BITS-1:0]     dp_b_q;
  logic [BITS-1:0]     dp_q_q;
  logic [2*BITS-1:0]   product_q;
  logic                start_ready_q;
  logic                load_q;
  logic                add_q;
  logic                shift_q;
  logic                res_valid_q;
  logic                busy_q;
  logic                err_q;

  logic cnt_zero;
  logic zero_mis;

  // Termination follows the internal count; the datapath's P may be narrower.
  assign cnt_zero = (cnt_q == '0);
  assign zero_mis = CHECK_ZERO && (Zero != cnt_zero);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      dp_b_q        <= '0;
      dp_q_q        <= '0;
      product_q     <= '0;
      start_ready_q <= 1'b1;
      load_q        <= 1'b0;
      add_q         <= 1'b0;
      shift_q       <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_q       <= LOAD;
            dp_b_q        <= op_b;
            dp_q_q        <= op_q;
            cnt_q         <= CW'(BITS);
            err_q         <= 1'b0;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            load_q        <= 1'b1;
          end
        end
        LOAD: begin
          state_q <= CHECK;
          load_q  <= 1'b0;
        end
        CHECK: begin
          if (cnt_zero) begin
            state_q     <= DONE;
            product_q   <= Producto[2*BITS-1:0];
            err_q       <= err_q | zero_mis | Producto[2*BITS];
            res_valid_q <= 1'b1;
          end else begin
            err_q <= err_q | zero_mis;
            if (Q0) begin
              state_q <= ADD;
              add_q   <= 1'b1;
            end else begin
              state_q <= SHIFT;
              shift_q <= 1'b1;
            end
          end
        end
        ADD: begin
          state_q <= SHIFT;
          add_q   <= 1'b0;
          shift_q <= 1'b1;
        end
        SHIFT: begin
          state_q <= CHECK;
          shift_q <= 1'b0;
          cnt_q   <= cnt_q - CW'(1);
        end
        DONE: begin
          if (res_ready) begin
            state_q       <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q       <= IDLE;
          load_q        <= 1'b0;
          add_q         <= 1'b0;
          shift_q       <= 1'b0;
          res_valid_q   <= 1'b0;
          busy_q        <= 1'b0;
          start_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign start_ready = start_ready_q;
  assign Load_Regs   = load_q;
  assign Add_Regs    = add_q;
  assign Shift_Regs  = shift_q;
  assign Decr_P      = shift_q;
  assign DP_B        = dp_b_q;
  assign DP_Q        = dp_q_q;
  assign res_valid   = res_valid_q;
  assign res_product = product_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_mult_shift_add_ctrl.sv
// Bench for mult_shift_add_ctrl: a behavioural shift-add datapath closes the loop,
// directed operand pairs feed a scoreboard checked when each result appears.
module tb_mult_shift_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [7:0]  op_b;
  logic [7:0]  op_q;
  logic        Q0;
  logic        Zero;
  logic [16:0] Producto;
  logic        Load_Regs;
  logic        Add_Regs;
  logic        Shift_Regs;
  logic        Decr_P;
  logic [7:0]  DP_B;
  logic [7:0]  DP_Q;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_product;
  logic        busy;
  logic        err;

  always #5 clk = ~clk;

  mult_shift_add_ctrl #(.BITS(8), .CHECK_ZERO(1'b1)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_b(op_b), .op_q(op_q),
    .Q0(Q0), .Zero(Zero), .Producto(Producto),
    .Load_Regs(Load_Regs), .Add_Regs(Add_Regs), .Shift_Regs(Shift_Regs), .Decr_P(Decr_P),
    .DP_B(DP_B), .DP_Q(DP_Q),
    .res_valid(res_valid), .res_ready(res_ready), .res_product(res_product),
    .busy(busy), .err(err)
  );

  // Datapath model: B, C, A, Q registers and P down-counter
  logic [7:0] b_m = '0;
  logic [7:0] a_m = '0;
  logic [7:0] q_m = '0;
  logic       c_m = 1'b0;
  logic [3:0] p_m = '0;
  logic       zero_force = 1'b0;

  always @(posedge clk) begin
    if (Load_Regs) begin
      b_m <= DP_B;
      q_m <= DP_Q;
      a_m <= '0;
      c_m <= 1'b0;
      p_m <= 4'd8;
    end else if (Add_Regs) begin
      {c_m, a_m} <= {1'b0, a_m} + {1'b0, b_m};
    end else if (Shift_Regs) begin
      {c_m, a_m, q_m} <= {1'b0, c_m, a_m, q_m[7:1]};
    end
    if (Decr_P) p_m <= p_m - 4'd1;
  end

  assign Q0       = q_m[0];
  assign Zero     = zero_force ? 1'b0 : (p_m == 4'd0);
  assign Producto = {c_m, a_m, q_m};

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [15:0] prod;
    int          lat;
    logic        err;
    int          adds;
  } exp_t;

  exp_t sb[$];

  // Monitor: counts pulses per operation, checks results as res_valid rises
  int   cyc = 0;
  int   acc_cyc = 0;
  int   adds = 0;
  int   shifts = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    chk("ctrl_exclusive", 32'(int'(Load_Regs) + int'(Add_Regs) + int'(Shift_Regs) <= 1), 32'd1);
    chk("decr_with_shift", {31'd0, Decr_P}, {31'd0, Shift_Regs});
    if (Load_Regs) begin
      acc_cyc = cyc - 1;
      adds    = 0;
      shifts  = 0;
    end
    if (Add_Regs)   adds++;
    if (Shift_Regs) shifts++;
    if (res_valid && !prev_v) begin
      if (sb.size() == 0) begin
        chk("unexpected_res_valid", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        $display("result: product=%04h latency=%0d err=%0b adds=%0d shifts=%0d",
                 res_product, cyc - acc_cyc, err, adds, shifts);
        chk("product", {16'd0, res_product}, {16'd0, e.prod});
        chk("latency", 32'(cyc - acc_cyc), 32'(e.lat));
        chk("err", {31'd0, err}, {31'd0, e.err});
        chk("add_pulses", 32'(adds), 32'(e.adds));
        chk("shift_pulses", 32'(shifts), 32'd8);
      end
    end
    prev_v = res_valid;
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic issue(input logic [7:0] b, input logic [7:0] q);
    bit got = 1'b0;
    start_valid = 1'b1;
    op_b = b;
    op_q = q;
    for (int i = 0; i < 50; i++) begin
      if (start_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    op_b = ~b;
    op_q = ~q;
  endtask

  task automatic wait_done();
    bit got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (res_valid && res_ready) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("idle_ready", {31'd0, start_ready}, 32'd1);
    chk("valid_dropped", {31'd0, res_valid}, 32'd0);
  endtask

  task automatic run_op(input logic [7:0] b, input logic [7:0] q, input logic [15:0] prod,
                        input int lat, input logic e_err, input int e_adds);
    exp_t e;
    e.prod = prod;
    e.lat  = lat;
    e.err  = e_err;
    e.adds = e_adds;
    sb.push_back(e);
    $display("issue: b=%02h q=%02h expect product=%04h latency=%0d", b, q, prod, lat);
    issue(b, q);
    wait_done();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit got;
    rst         = 1'b1;
    start_valid = 1'b0;
    op_b        = '0;
    op_q        = '0;
    res_ready   = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_product", {16'd0, res_product}, 32'd0);
    chk("rst_dp_b", {24'd0, DP_B}, 32'd0);

    run_op(8'd3,   8'd5,   16'd15,    21, 1'b0, 2);
    run_op(8'hFF,  8'hFF,  16'hFE01,  27, 1'b0, 8);
    run_op(8'hAB,  8'h00,  16'h0000,  19, 1'b0, 0);
    run_op(8'h80,  8'h80,  16'h4000,  20, 1'b0, 1);

    // Back-pressure: result held ten cycles, new operands offered meanwhile
    res_ready = 1'b0;
    run_op_bp: begin
      exp_t e;
      e.prod = 16'h03A8;
      e.lat  = 22;
      e.err  = 1'b0;
      e.adds = 3;
      sb.push_back(e);
      $display("issue: b=12 q=34 expect product=03a8 latency=22 with back-pressure");
      issue(8'h12, 8'h34);
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (res_valid) begin
          got = 1'b1;
          break;
        end
        @(negedge clk);
      end
      if (!got) chk("bp_valid_timeout", 32'd0, 32'd1);
      for (int k = 0; k < 10; k++) begin
        start_valid = 1'b1;
        op_b = 8'h77;
        op_q = 8'h66;
        @(negedge clk);
        chk("bp_valid_held", {31'd0, res_valid}, 32'd1);
        chk("bp_product_held", {16'd0, res_product}, 32'h03A8);
        chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
        chk("bp_dp_b", {24'd0, DP_B}, 32'h12);
        chk("bp_dp_q", {24'd0, DP_Q}, 32'h34);
      end
      start_valid = 1'b0;
      res_ready   = 1'b1;
      @(negedge clk);
      chk("bp_released", {31'd0, res_valid}, 32'd0);
      chk("bp_idle_ready", {31'd0, start_ready}, 32'd1);
      chk("bp_not_accepted", {24'd0, DP_B}, 32'h12);
    end

    // Reset during the fourth shift, then a clean operation
    $display("issue: b=55 q=0f aborted by reset on 4th shift");
    issue(8'h55, 8'h0F);
    n = 0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Shift_Regs) n++;
      if (n == 4) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) chk("shift4_timeout", 32'd0, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_res_valid", {31'd0, res_valid}, 32'd0);
    chk("abort_ctrl", {28'd0, Load_Regs, Add_Regs, Shift_Regs, Decr_P}, 32'd0);
    chk("abort_dp", {16'd0, DP_B, DP_Q}, 32'd0);
    chk("abort_start_ready", {31'd0, start_ready}, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    run_op(8'd7,   8'd9,   16'd63,    21, 1'b0, 2);

    // Zero held low: err flags the mismatch, product unaffected
    zero_force = 1'b1;
    run_op(8'h0C,  8'h0A,  16'h0078,  21, 1'b1, 2);
    zero_force = 1'b0;
    run_op(8'h01,  8'hFF,  16'h00FF,  27, 1'b0, 8);

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
